// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and single-cycle special cases.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;   // mul: {hi, multiplier}; div: low half = quotient
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN-1:0]     opnd_q, opnd_d; // multiplicand or divisor magnitude
  logic [XLEN-1:0]     result_q, result_d;
  logic                dz_q, dz_d;

  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              accept, sp_dz, sp_ovf;
  logic [XLEN:0]     mul_sum, mul_hi, div_shl, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  always_comb begin
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign_a   = signed_a && op_a[XLEN-1];
    sign_b   = signed_b && op_b[XLEN-1];
    mag_a    = sign_a ? (~op_a + 1'b1) : op_a;
    mag_b    = sign_b ? (~op_b + 1'b1) : op_b;
    accept   = start && !flush && (state_q == IDLE);
    sp_dz    = funct3[2] && (op_b == '0);
    sp_ovf   = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  end

  // One iteration of each algorithm; CALC picks the one matching the latched op.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_hi   = acc_q[0] ? mul_sum : {1'b0, acc_q[2*XLEN-1:XLEN]};
    div_shl  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    div_diff = div_shl - {1'b0, opnd_q};
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    dz_d     = dz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d = funct3;
          if (sp_dz) begin
            result_d = funct3[1] ? op_a : '1;
            dz_d     = 1'b1;
            state_d  = DONE;
          end else if (sp_ovf) begin
            result_d = funct3[1] ? '0 : op_a;
            dz_d     = 1'b0;
            state_d  = DONE;
          end else begin
            // REM takes the dividend's sign; everything else the product of signs
            neg_d   = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
            cnt_d   = CNT_W'(XLEN);
            rem_d   = '0;
            state_d = CALC;
            if (funct3[2]) begin
              acc_d  = {{XLEN{1'b0}}, mag_a};
              opnd_d = mag_b;
            end else begin
              acc_d  = {{XLEN{1'b0}}, mag_b};
              opnd_d = mag_a;
            end
          end
        end
      end
      CALC: begin
        if (f3_q[2]) begin
          if (!div_diff[XLEN]) begin
            rem_d = div_diff;
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = div_shl;
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_hi, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (flush)            state_d = IDLE;
        else if (cnt_q == 1)  state_d = FIX;
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          unique case (f3_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quot_fix;
            default:                result_d = rem_fix;
          endcase
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE) && !flush;
  assign result   = result_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned results, special cases,
// handshake corner cases, flush and asynchronous reset mid-operation.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        ready, done, div_zero;
  logic [31:0] result;

  int n_chk = 0;
  int n_pass = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .ready(ready), .done(done), .result(result),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one op at a negedge, scramble operands after accept, time done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_dz);
    int n;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_dz"}, 32'(div_zero), 32'(exp_dz));
    @(negedge clk);
  endtask

  // Watch for a stray done pulse over a window.
  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int t1, t2, n;
    logic [31:0] prev;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Special cases first so reset has something non-zero to clear
    run_op("div_by0", 3'b100, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);

    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done("midrst_nodone", 40);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 34, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 1'b0);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 34, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 1'b0);
    run_op("divu", 3'b101, 32'hFFFF_FFFE, 32'd2, 34, 32'h7FFF_FFFF, 1'b0);
    run_op("remu", 3'b111, 32'd10, 32'd3, 34, 32'd1, 1'b0);
    run_op("div_pos", 3'b100, 32'd100, 32'hFFFF_FFF9, 34, 32'hFFFF_FFF2, 1'b0);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 1, 32'd5, 1'b1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1'b0);

    // start held high: second done lands XLEN+3 cycles after the first
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    t1 = -1; t2 = -1; n = 0;
    while (t2 < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 < 0) t1 = n;
        else begin t2 = n; start = 1'b0; end
      end
    end
    start = 1'b0;
    chk("b2b_first", 32'(t1), 32'd34);
    chk("b2b_spacing", 32'(t2 - t1), 32'd35);
    chk("b2b_res", result, 32'd6);
    @(negedge clk);

    // start together with flush in IDLE is not an accept
    prev = result;
    funct3 = 3'b011; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("sf_ready", 32'(ready), 32'd1);
    no_done("sf_nodone", 40);
    chk("sf_result", result, prev);

    // Flush ten cycles into MULHU
    prev = result;
    funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_result", result, prev);
    no_done("flush_nodone", 40);
    chk("flush_result2", result, prev);
    run_op("mul_after", 3'b000, 32'd3, 32'd4, 34, 32'd12, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, selected by funct3.
- Sits beside the single-cycle ALU in the execute stage. It is used when the main decoder flags an M-extension op (opcode 0110011, funct7 = 0000001).
- The pipeline stalls while the unit is not ready, then takes the result on the done pulse.
- Width is parametrised. Multiply and divide run radix-2, one bit per cycle.

Parameters:
- XLEN, 32, operand and result width. Must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- flush  input  1  abort the in-flight op (pipeline kill)
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value
- op_b  input  XLEN  rs2 value
- ready  output  1  unit idle, can accept
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  op result; held until the next accept
- div_zero  output  1  last completed op was DIV/DIVU/REM/REMU with op_b=0; held like result

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, ready=1, done=0, result=0, div_zero=0.
  - Counter and internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- Accept:
  - start=1 and state=IDLE and flush=0 at a rising edge.
  - funct3, op_a and op_b are latched at that edge. The inputs may change afterwards.
- IDLE -> CALC on a normal accept:
  - Load the absolute values of signed operands:
    - MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - DIV/REM: both operands signed.
  - Record the result sign:
    - MUL-family: sign = sign_a XOR sign_b.
    - DIV: sign = sign_a XOR sign_b.
    - REM: sign = sign of dividend.
  - Counter := XLEN.
- IDLE -> DONE on a special-case accept (no CALC):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = op_a; div_zero=1.
  - Signed overflow (op_a = 1 followed by XLEN-1 zeros, op_b = all ones):
    - DIV result = op_a; REM result = 0.
- CALC, one iteration per cycle, counter decrements:
  - Multiply: 2*XLEN-bit shift-add. Add the multiplicand when the LSB of the multiplier is 1; shift right.
  - Divide: restoring. Shift {rem,quot} left by 1, trial subtract the divisor, set the quotient LSB on success.
  - Counter = 1 at an edge: next state FIX.
- FIX, one cycle:
  - Conditional two's-complement negate.
  - Select the output word:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Write result. Set div_zero=0. Go to DONE.
- DONE, one cycle:
  - done=1, ready=0. Next state IDLE.
- Outputs:
  - ready = (state==IDLE). Registered state decode; no combinational path from start.
  - done is high only in the DONE state.
- Latency, counted from the cycle in which start is sampled high to the cycle in which done is high:
  - Normal op: XLEN+2 cycles (34 at XLEN=32).
  - Special case: 1 cycle.
  - Back-to-back throughput: one op per XLEN+3 cycles (DONE plus IDLE).
- Flush:
  - In CALC, FIX or DONE: next state IDLE. done is not asserted (DONE state suppresses done when flush=1).
  - result and div_zero keep their previous values.
- start and flush both high in IDLE: flush wins, no accept.
- start while ready=0: ignored, no queuing.
- Reset mid-operation: immediate abort to reset values. No done pulse.
- Arithmetic:
  - All internal magnitudes are XLEN bits unsigned. The product accumulator is 2*XLEN bits.
  - The divider partial remainder is XLEN+1 bits so the trial subtract does not overflow.

Test Plan:
1. Reset: assert rst_n=0 mid-CALC of DIV 100/7 -> outputs reset immediately (ready=1, done=0, result=0); no done after release.
2. Multiply: MUL 7*(-3) -> result=0xFFFFFFEB, done exactly 34 cycles after start. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU -1*2 -> 0xFFFFFFFF.
3. Divide signs:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
   - DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF; REMU 10/3 -> 1.
4. Special cases, each with done after 1 cycle:
   - DIV 5/0 -> 0xFFFFFFFF, div_zero=1.
   - REMU 5/0 -> 5.
   - DIV 0x80000000/-1 -> 0x80000000.
   - REM 0x80000000/-1 -> 0.
5. Handshake:
   - start held high continuously -> ops accepted every 35 cycles.
   - Operand change during CALC -> no effect on result.
   - start and flush together in IDLE -> nothing accepted.
6. Flush: assert at cycle 10 of MULHU -> no done, ready=1 next cycle, prior result unchanged. A following MUL 3*4 -> result=12.
